// File: rtl/push_conditioner.sv
// push_conditioner
//   Input stage for the push-button service logic. Each button is run through
//   a 2-flop synchroniser and a debouncer. The result is a clean level plus
//   one-cycle press/release strobes. While a button is held, an optional
//   auto-repeat re-fires the press strobe. Buttons are fully independent.
//
// Ports
//   clk_osc      in   1      system clock
//   rst          in   1      synchronous, active-high reset
//   push_raw     in   N_BTN  asynchronous, bouncy button inputs
//   repeat_en    in   N_BTN  per-button auto-repeat enable (clk_osc domain)
//   btn_level    out  N_BTN  debounced button level
//   btn_press    out  N_BTN  1-cycle strobe on accepted press and on each repeat
//   btn_release  out  N_BTN  1-cycle strobe on accepted release
//   btn_repeat   out  N_BTN  high while the button is in the auto-repeat phase
module push_conditioner #(
  parameter int N_BTN            = 5,
  parameter int DEBOUNCE_CYC     = 1_000_000,
  parameter int REPEAT_DELAY_CYC = 50_000_000,
  parameter int REPEAT_RATE_CYC  = 10_000_000
) (
  input  logic             clk_osc,
  input  logic             rst,
  input  logic [N_BTN-1:0] push_raw,
  input  logic [N_BTN-1:0] repeat_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                               : REPEAT_RATE_CYC;
  localparam int RP_W   = $clog2(RP_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYC);
  // The repeat counter is cleared on the event edge and reads 0 in the first
  // cycle after it, so the event fires when it holds CYC-1.
  localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE_CYC - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  // Stage p0/p1: two-flop synchroniser, the only reader of push_raw.
  logic [N_BTN-1:0] sync_p0;
  logic [N_BTN-1:0] sync_p1;

  always_ff @(posedge clk_osc) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= push_raw;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_nxt;
    logic            level_r;
    logic            level_nxt;
    logic            rise;
    logic            fall;
    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [RP_W-1:0] rp_cnt;
    logic [RP_W-1:0] rp_nxt;
    logic            rp_hit;
    logic            press_r;
    logic            release_r;
    logic            repeat_r;

    // Stage p2: debounce, strobe generation and auto-repeat sequencing.
    always_comb begin
      db_nxt    = '0;
      level_nxt = level_r;
      if (sync_p1[i] != level_r) begin
        if (db_cnt == DB_LAST) begin
          level_nxt = ~level_r;
        end else begin
          db_nxt = db_cnt + 1'b1;
        end
      end
      rise = level_nxt & ~level_r;
      fall = ~level_nxt & level_r;

      state_nxt = state;
      rp_nxt    = rp_cnt;
      rp_hit    = 1'b0;
      // A falling level wins over any repeat due in the same cycle.
      if (fall) begin
        state_nxt = ST_IDLE;
        rp_nxt    = '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rise) begin
              state_nxt = ST_DELAY;
              rp_nxt    = '0;
            end
          end
          ST_DELAY: begin
            if (rp_cnt == DELAY_LAST) begin
              state_nxt = ST_REPEAT;
              rp_nxt    = '0;
              rp_hit    = 1'b1;
            end else begin
              rp_nxt = rp_cnt + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (rp_cnt == RATE_LAST) begin
              rp_nxt = '0;
              rp_hit = 1'b1;
            end else begin
              rp_nxt = rp_cnt + 1'b1;
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            rp_nxt    = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk_osc) begin
      if (rst) begin
        db_cnt    <= '0;
        level_r   <= 1'b0;
        state     <= ST_IDLE;
        rp_cnt    <= '0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        repeat_r  <= 1'b0;
      end else begin
        db_cnt    <= db_nxt;
        level_r   <= level_nxt;
        state     <= state_nxt;
        rp_cnt    <= rp_nxt;
        // repeat_en only masks the strobe; the cadence keeps running.
        press_r   <= rise | (rp_hit & repeat_en[i]);
        release_r <= fall;
        repeat_r  <= (state_nxt == ST_REPEAT);
      end
    end

    assign btn_level[i]   = level_r;
    assign btn_press[i]   = press_r;
    assign btn_release[i] = release_r;
    assign btn_repeat[i]  = repeat_r;
  end

endmodule

// File: tb/tb_push_conditioner.sv
// tb_push_conditioner
//   Scoreboard bench for push_conditioner with short timing parameters.
//   The driver applies one input vector per clock and pushes the expected
//   outputs from a behavioural model; a monitor pops and compares after
//   every rising edge.
module tb_push_conditioner;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RR = 8;

  logic         clk_osc = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] push_raw = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_repeat;

  push_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR)
  ) dut (
    .clk_osc(clk_osc), .rst(rst), .push_raw(push_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .btn_press(btn_press),
    .btn_release(btn_release), .btn_repeat(btn_repeat)
  );

  always #5 clk_osc = ~clk_osc;

  typedef struct packed {
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] rel;
    logic [N-1:0] rep;
  } exp_t;

  exp_t         exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;

  // Reference model state: debounced level, raw samples as seen through the
  // two-cycle synchroniser delay, and the cycle of the last real press.
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_hist[$];
  int           m_press_t[N];
  int           m_cyc = 0;

  task automatic model_edge(input logic r, input logic [N-1:0] raw,
                            input logic [N-1:0] en);
    exp_t         e;
    logic [N-1:0] nl;
    bit           all_diff;
    int           d;
    e = '0;
    if (r) begin
      m_level = '0;
      m_hist.delete();
      for (int k = 0; k < D + 2; k++) m_hist.push_back('0);
    end else begin
      nl = m_level;
      for (int b = 0; b < N; b++) begin
        // Level flips once the last D+1 synchronised samples all disagree.
        all_diff = 1'b1;
        for (int k = 0; k <= D; k++)
          if (m_hist[k][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) nl[b] = ~m_level[b];
        if (nl[b] && !m_level[b]) begin
          e.press[b]   = 1'b1;
          m_press_t[b] = m_cyc;
        end else if (!nl[b] && m_level[b]) begin
          e.rel[b] = 1'b1;
        end else if (nl[b]) begin
          d = m_cyc - m_press_t[b];
          if (d >= RD) e.rep[b] = 1'b1;
          if ((d == RD || (d > RD && (d - RD) % RR == 0)) && en[b])
            e.press[b] = 1'b1;
        end
      end
      e.level = nl;
      m_level = nl;
      m_hist.push_back(raw);
      void'(m_hist.pop_front());
    end
    m_cyc++;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic r, input logic [N-1:0] raw,
                      input logic [N-1:0] en);
    @(negedge clk_osc);
    rst       = r;
    push_raw  = raw;
    repeat_en = en;
    model_edge(r, raw, en);
  endtask

  task automatic hold(input int n, input logic [N-1:0] raw,
                      input logic [N-1:0] en);
    for (int c = 0; c < n; c++) step(1'b0, raw, en);
  endtask

  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clk_osc);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {btn_level, btn_press, btn_release, btn_repeat};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t: got lvl=%b prs=%b rel=%b rep=%b, need lvl=%b prs=%b rel=%b rep=%b",
                   $time, got.level, got.press, got.rel, got.rep,
                   e.level, e.press, e.rel, e.rep);
        end
      end
    end
  end

  initial begin : driver
    logic [N-1:0] raw_r;
    logic [N-1:0] en_r;
    int           seg[N];
    bit           bouncy[N];

    // Reset with all buttons held, then release into a fresh press.
    for (int c = 0; c < 3; c++) step(1'b1, 5'b11111, 5'b00000);
    hold(10, 5'b11111, 5'b00000);
    hold(12, 5'b00000, 5'b00000);

    // Clean press on button 0, no repeat.
    hold(40, 5'b00001, 5'b00000);
    hold(12, 5'b00000, 5'b00000);

    // Bounce on button 2 that never settles long enough.
    for (int c = 0; c < 20; c++)
      step(1'b0, ((c / 2) % 2 == 0) ? 5'b00100 : 5'b00000, 5'b00000);
    hold(10, 5'b00000, 5'b00000);

    // Auto-repeat on button 0; release lands on a repeat slot.
    hold(60, 5'b00001, 5'b00001);
    hold(12, 5'b00000, 5'b00001);

    // Two buttons together, repeat enabled only on button 0.
    hold(60, 5'b00011, 5'b00001);
    hold(12, 5'b00000, 5'b00001);

    // Reset in the middle of a repeating hold.
    hold(30, 5'b00001, 5'b00001);
    step(1'b1, 5'b00001, 5'b00001);
    step(1'b1, 5'b00001, 5'b00001);
    hold(50, 5'b00001, 5'b00001);
    hold(12, 5'b00000, 5'b00001);

    // Randomised holds, bounces, enable changes and occasional resets.
    raw_r = '0;
    en_r  = '1;
    for (int b = 0; b < N; b++) begin
      seg[b]    = 0;
      bouncy[b] = 1'b0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < N; b++) begin
        if (seg[b] == 0) begin
          seg[b]    = $urandom_range(1, 45);
          raw_r[b]  = ~raw_r[b];
          bouncy[b] = ($urandom_range(0, 3) == 0);
        end else if (bouncy[b] && $urandom_range(0, 2) == 0) begin
          raw_r[b] = ~raw_r[b];
        end
        seg[b]--;
      end
      if ($urandom_range(0, 49) == 0) en_r = N'($urandom);
      step(($urandom_range(0, 399) == 0), raw_r, en_r);
    end
    hold(15, 5'b00000, en_r);

    @(negedge clk_osc);
    @(negedge clk_osc);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
